// File: rtl/pipe_pkg.sv
// Shared definitions for the pipelined mux/arbiter family.
// Holds select-mode encodings and the round-robin index helper.
package pipe_pkg;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester after ptr,
// scanning upward modulo N.
module rr_arbiter
    import pipe_pkg::*;
#(
    parameter  int N    = 4,
    localparam int SELW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic            gnt_valid,
    output logic [SELW-1:0] gnt_idx
);

    int cand;

    // First match wins; later candidates are ignored once a grant is found.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = int'(ptr);
        for (int k = 0; k < N; k++) begin
            cand = rr_next(cand, N);
            if (!gnt_valid && req[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = SELW'(cand);
            end
        end
    end

endmodule

// File: rtl/pipe_mux_arb.sv
// Registered N:1 mux with valid/ready on every port, selectable between an
// explicit channel select and round-robin arbitration.
module pipe_mux_arb
    import pipe_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int N     = 4,
    localparam int SELW  = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [SELW-1:0]    sel,
    input  logic               mode_rr,
    input  logic               flush,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_sel,
    output logic               out_valid,
    input  logic               out_ready
);

    logic [SELW-1:0] rr_ptr;
    logic            rr_gnt_valid;
    logic [SELW-1:0] rr_gnt_idx;
    logic            sel_gnt_valid;
    logic            grant_valid;
    logic [SELW-1:0] grant_idx;
    logic            can_load;
    logic            load;

    rr_arbiter #(.N(N)) u_rr_arbiter (
        .req       (in_valid),
        .ptr       (rr_ptr),
        .gnt_valid (rr_gnt_valid),
        .gnt_idx   (rr_gnt_idx)
    );

    // An out-of-range select (possible when N is not a power of two) never grants.
    always_comb begin
        sel_gnt_valid = 1'b0;
        if (int'(sel) < N) begin
            sel_gnt_valid = in_valid[sel];
        end
    end

    always_comb begin
        if (mode_rr == MODE_RR) begin
            grant_valid = rr_gnt_valid;
            grant_idx   = rr_gnt_idx;
        end else begin
            grant_valid = sel_gnt_valid;
            grant_idx   = sel;
        end
    end

    // Reset also blocks acceptance so no producer sees a handshake it will lose.
    assign can_load = !rst && !flush && (!out_valid || out_ready);
    assign load     = can_load && grant_valid;

    always_comb begin
        in_ready = '0;
        if (load) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    // Loading takes precedence over draining so back-to-back transfers have no bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            rr_ptr    <= SELW'(N - 1);
        end else if (load) begin
            out_data  <= in_data[grant_idx*WIDTH +: WIDTH];
            out_sel   <= grant_idx;
            out_valid <= 1'b1;
            rr_ptr    <= grant_idx;
        end else if (flush || out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pipe_mux_arb.sv
// Directed self-checking bench for pipe_mux_arb: a 4x8 instance for the main
// behaviour and a 3x32 instance for reset restart and out-of-range select.
module tb_pipe_mux_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Instance A: N=4, WIDTH=8
    logic        rst_a;
    logic [31:0] in_data_a;
    logic [3:0]  in_valid_a;
    logic [3:0]  in_ready_a;
    logic [1:0]  sel_a;
    logic        mode_a;
    logic        flush_a;
    logic [7:0]  out_data_a;
    logic [1:0]  out_sel_a;
    logic        out_valid_a;
    logic        out_ready_a;

    pipe_mux_arb #(.WIDTH(8), .N(4)) dut_a (
        .clk       (clk),
        .rst       (rst_a),
        .in_data   (in_data_a),
        .in_valid  (in_valid_a),
        .in_ready  (in_ready_a),
        .sel       (sel_a),
        .mode_rr   (mode_a),
        .flush     (flush_a),
        .out_data  (out_data_a),
        .out_sel   (out_sel_a),
        .out_valid (out_valid_a),
        .out_ready (out_ready_a)
    );

    // Instance B: N=3, WIDTH=32
    logic        rst_b;
    logic [95:0] in_data_b;
    logic [2:0]  in_valid_b;
    logic [2:0]  in_ready_b;
    logic [1:0]  sel_b;
    logic        mode_b;
    logic        flush_b;
    logic [31:0] out_data_b;
    logic [1:0]  out_sel_b;
    logic        out_valid_b;
    logic        out_ready_b;

    pipe_mux_arb #(.WIDTH(32), .N(3)) dut_b (
        .clk       (clk),
        .rst       (rst_b),
        .in_data   (in_data_b),
        .in_valid  (in_valid_b),
        .in_ready  (in_ready_b),
        .sel       (sel_b),
        .mode_rr   (mode_b),
        .flush     (flush_b),
        .out_data  (out_data_b),
        .out_sel   (out_sel_b),
        .out_valid (out_valid_b),
        .out_ready (out_ready_b)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out_a(input string tag, input logic v, input logic [1:0] s, input logic [7:0] d);
        check({tag, ".valid"}, 64'(out_valid_a), 64'(v));
        check({tag, ".sel"},   64'(out_sel_a),   64'(s));
        check({tag, ".data"},  64'(out_data_a),  64'(d));
    endtask

    task automatic check_out_b(input string tag, input logic v, input logic [1:0] s, input logic [31:0] d);
        check({tag, ".valid"}, 64'(out_valid_b), 64'(v));
        check({tag, ".sel"},   64'(out_sel_b),   64'(s));
        check({tag, ".data"},  64'(out_data_b),  64'(d));
    endtask

    initial begin
        rst_a = 1'b1; in_valid_a = 4'b1111; sel_a = 2'd0; mode_a = 1'b1;
        flush_a = 1'b0; out_ready_a = 1'b1;
        in_data_a = {8'h13, 8'h12, 8'h11, 8'h10};
        rst_b = 1'b1; in_valid_b = 3'b111; sel_b = 2'd0; mode_b = 1'b1;
        flush_b = 1'b0; out_ready_b = 1'b1;
        in_data_b = {32'hCAFE0002, 32'hCAFE0001, 32'hCAFE0000};

        // Reset held two cycles with every channel valid
        #1;
        check("rst_in_ready0", 64'(in_ready_a), 64'h0);
        tick();
        check_out_a("rst_c1", 1'b0, 2'd0, 8'h00);
        check("rst_in_ready1", 64'(in_ready_a), 64'h0);
        tick();
        check_out_a("rst_c2", 1'b0, 2'd0, 8'h00);
        check("rst_in_ready2", 64'(in_ready_a), 64'h0);

        // First post-reset round-robin grant goes to channel 0
        rst_a = 1'b0;
        #1;
        check("post_rst_grant", 64'(in_ready_a), 64'b0001);
        tick();
        check_out_a("rr0", 1'b1, 2'd0, 8'h10);

        // Round-robin fairness with all channels valid, including wrap
        tick(); check_out_a("rr1", 1'b1, 2'd1, 8'h11);
        tick(); check_out_a("rr2", 1'b1, 2'd2, 8'h12);
        tick(); check_out_a("rr3", 1'b1, 2'd3, 8'h13);
        tick(); check_out_a("rr_wrap", 1'b1, 2'd0, 8'h10);

        // Only channels 1 and 3 requesting: grants alternate
        in_valid_a = 4'b1010;
        #1;
        check("rr_alt_ready", 64'(in_ready_a), 64'b0010);
        tick(); check_out_a("alt0", 1'b1, 2'd1, 8'h11);
        tick(); check_out_a("alt1", 1'b1, 2'd3, 8'h13);
        tick(); check_out_a("alt2", 1'b1, 2'd1, 8'h11);
        tick(); check_out_a("alt3", 1'b1, 2'd3, 8'h13);

        // Explicit select of channel 2
        mode_a = 1'b0; sel_a = 2'd2; in_valid_a = 4'b0100;
        in_data_a = {8'h13, 8'hA5, 8'h11, 8'h10};
        #1;
        check("sel2_ready", 64'(in_ready_a), 64'b0100);
        tick();
        check_out_a("sel2_out", 1'b1, 2'd2, 8'hA5);

        // Select points at an idle channel: no grant, output drains
        sel_a = 2'd3;
        #1;
        check("sel3_ready", 64'(in_ready_a), 64'h0);
        tick();
        check_out_a("sel3_out", 1'b0, 2'd2, 8'hA5);

        // Load channel 1 explicitly, then stall for three cycles
        in_data_a = {8'h13, 8'h12, 8'h11, 8'h10};
        sel_a = 2'd1; in_valid_a = 4'b0010;
        tick();
        check_out_a("pre_stall", 1'b1, 2'd1, 8'h11);
        out_ready_a = 1'b0; mode_a = 1'b1; in_valid_a = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_ready", 64'(in_ready_a), 64'h0);
            tick();
            check_out_a("stall_hold", 1'b1, 2'd1, 8'h11);
        end

        // Releasing the stall accepts the next channel on the same edge
        out_ready_a = 1'b1;
        #1;
        check("unstall_ready", 64'(in_ready_a), 64'b0100);
        tick();
        check_out_a("unstall_out", 1'b1, 2'd2, 8'h12);

        // Flush while stalled: output killed, pointer untouched
        out_ready_a = 1'b0; flush_a = 1'b1;
        #1;
        check("flush_ready", 64'(in_ready_a), 64'h0);
        tick();
        check_out_a("flush_out", 1'b0, 2'd2, 8'h12);
        flush_a = 1'b0; out_ready_a = 1'b1;
        #1;
        check("post_flush_ready", 64'(in_ready_a), 64'b1000);
        tick();
        check_out_a("post_flush_out", 1'b1, 2'd3, 8'h13);

        // Flush overrides out_ready and still blocks acceptance
        flush_a = 1'b1;
        #1;
        check("flush_rdy_hi_ready", 64'(in_ready_a), 64'h0);
        tick();
        check_out_a("flush_rdy_hi_out", 1'b0, 2'd3, 8'h13);
        flush_a = 1'b0;
        #1;
        check("flush_rdy_hi_next", 64'(in_ready_a), 64'b0001);

        // N=3 instance: traffic, mid-stream reset, grant order restarts at 0
        rst_b = 1'b0;
        #1;
        check("b_first_ready", 64'(in_ready_b), 64'b001);
        tick(); check_out_b("b_rr0", 1'b1, 2'd0, 32'hCAFE0000);
        tick(); check_out_b("b_rr1", 1'b1, 2'd1, 32'hCAFE0001);
        rst_b = 1'b1;
        #1;
        check("b_rst_ready", 64'(in_ready_b), 64'h0);
        tick();
        check_out_b("b_rst_out", 1'b0, 2'd0, 32'h0);
        rst_b = 1'b0;
        #1;
        check("b_restart_ready", 64'(in_ready_b), 64'b001);
        tick(); check_out_b("b_re0", 1'b1, 2'd0, 32'hCAFE0000);
        tick(); check_out_b("b_re1", 1'b1, 2'd1, 32'hCAFE0001);
        tick(); check_out_b("b_re2", 1'b1, 2'd2, 32'hCAFE0002);
        tick(); check_out_b("b_wrap", 1'b1, 2'd0, 32'hCAFE0000);

        // Out-of-range explicit select on N=3 never grants
        mode_b = 1'b0; sel_b = 2'd3;
        #1;
        check("b_oor_ready", 64'(in_ready_b), 64'h0);
        tick();
        check_out_b("b_oor_out", 1'b0, 2'd0, 32'hCAFE0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
